// File: rtl/mux_key.sv
// Content-addressed key->data multiplexer: OR-merges the data of every lut entry
// whose key matches, falls back to default_out on a miss, and keeps a registered copy.
module mux_key #(
  parameter int unsigned NR_KEY   = 2,
  parameter int unsigned KEY_LEN  = 1,
  parameter int unsigned DATA_LEN = 1
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [KEY_LEN-1:0]                      key,
  input  logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0]    lut,
  input  logic [DATA_LEN-1:0]                     default_out,
  input  logic                                    en,
  output logic [DATA_LEN-1:0]                     out,
  output logic                                    hit,
  output logic                                    multi_hit,
  output logic [DATA_LEN-1:0]                     out_q,
  output logic                                    hit_q
);

  localparam int unsigned W = KEY_LEN + DATA_LEN;

  logic [NR_KEY-1:0]   match;
  logic [DATA_LEN-1:0] or_chain  [NR_KEY+1];
  logic                seen_one  [NR_KEY+1];
  logic                seen_two  [NR_KEY+1];

  assign or_chain[0] = '0;
  assign seen_one[0] = 1'b0;
  assign seen_two[0] = 1'b0;

  // Per-entry compare; the running chains give the OR-merge and a saturating 2-count.
  for (genvar i = 0; i < int'(NR_KEY); i++) begin : g_entry
    logic [KEY_LEN-1:0]  entry_key;
    logic [DATA_LEN-1:0] entry_data;

    assign entry_key   = lut[i*W + DATA_LEN +: KEY_LEN];
    assign entry_data  = lut[i*W +: DATA_LEN];
    assign match[i]    = (entry_key == key);

    assign or_chain[i+1] = or_chain[i] | ({DATA_LEN{match[i]}} & entry_data);
    assign seen_one[i+1] = seen_one[i] | match[i];
    assign seen_two[i+1] = seen_two[i] | (seen_one[i] & match[i]);
  end

  assign hit       = seen_one[NR_KEY];
  assign multi_hit = seen_two[NR_KEY];
  assign out       = hit ? or_chain[NR_KEY] : default_out;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q <= '0;
      hit_q <= 1'b0;
    end else if (en) begin
      out_q <= out;
      hit_q <= hit;
    end
  end

endmodule

// File: tb/tb_mux_key.sv
// Directed bench for mux_key: 4-entry byte table, 64-bit lane select, and a
// single-entry table, each with hand-computed expected values.
module tb_mux_key;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 4-entry, 3-bit key, 8-bit data
  logic [2:0]  key_a;
  logic [43:0] lut_a;
  logic [7:0]  def_a;
  logic        en_a;
  logic [7:0]  out_a, out_q_a;
  logic        hit_a, multi_a, hit_q_a;

  // 2-entry, 3-bit key, 64-bit data
  logic [2:0]   key_b;
  logic [133:0] lut_b;
  logic [63:0]  def_b;
  logic [63:0]  out_b, out_q_b;
  logic         hit_b, multi_b, hit_q_b;

  // 1-entry, 2-bit key, 4-bit data
  logic [1:0] key_c;
  logic [5:0] lut_c;
  logic [3:0] def_c;
  logic [3:0] out_c, out_q_c;
  logic       hit_c, multi_c, hit_q_c;

  int pass_cnt = 0;
  int total    = 0;

  mux_key #(.NR_KEY(4), .KEY_LEN(3), .DATA_LEN(8)) dut_a (
    .clk(clk), .rst(rst), .key(key_a), .lut(lut_a), .default_out(def_a), .en(en_a),
    .out(out_a), .hit(hit_a), .multi_hit(multi_a), .out_q(out_q_a), .hit_q(hit_q_a)
  );

  mux_key #(.NR_KEY(2), .KEY_LEN(3), .DATA_LEN(64)) dut_b (
    .clk(clk), .rst(rst), .key(key_b), .lut(lut_b), .default_out(def_b), .en(1'b1),
    .out(out_b), .hit(hit_b), .multi_hit(multi_b), .out_q(out_q_b), .hit_q(hit_q_b)
  );

  mux_key #(.NR_KEY(1), .KEY_LEN(2), .DATA_LEN(4)) dut_c (
    .clk(clk), .rst(rst), .key(key_c), .lut(lut_c), .default_out(def_c), .en(1'b1),
    .out(out_c), .hit(hit_c), .multi_hit(multi_c), .out_q(out_q_c), .hit_q(hit_q_c)
  );

  localparam logic [43:0] LUT_T1 = {3'd0, 8'h01, 3'd1, 8'h03, 3'd2, 8'h0f, 3'd3, 8'hff};
  localparam logic [43:0] LUT_T3 = {3'd2, 8'h0f, 3'd2, 8'hf0, 3'd1, 8'h03, 3'd0, 8'h01};
  localparam logic [63:0] LO32   = 64'h0000_0000_ffff_ffff;
  localparam logic [63:0] HI32   = 64'hffff_ffff_0000_0000;

  task automatic test_reset();
    rst  = 1'b1;
    en_a = 1'b1;
    key_a = 3'd3; lut_a = LUT_T1; def_a = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (out_q_a !== 8'h00) $display("FAIL reset_out_q: got %h expected 00", out_q_a);
    else pass_cnt++;
    total++;
    if (hit_q_a !== 1'b0) $display("FAIL reset_hit_q: got %b expected 0", hit_q_a);
    else pass_cnt++;
    total++;
    if (out_a !== 8'hff) $display("FAIL reset_comb_out: got %h expected ff", out_a);
    else pass_cnt++;
    @(negedge clk);
    rst  = 1'b0;
    en_a = 1'b0;
  endtask

  task automatic test_lookup();
    logic [7:0] exp_tab [4];
    exp_tab[0] = 8'h01; exp_tab[1] = 8'h03; exp_tab[2] = 8'h0f; exp_tab[3] = 8'hff;
    lut_a = LUT_T1;
    def_a = 8'h5a;
    for (int k = 0; k < 4; k++) begin
      key_a = 3'(k);
      #1;
      total++;
      if (out_a !== exp_tab[k] || hit_a !== 1'b1 || multi_a !== 1'b0)
        $display("FAIL lookup key=%0d: got out=%h hit=%b multi=%b expected out=%h hit=1 multi=0",
                 k, out_a, hit_a, multi_a, exp_tab[k]);
      else pass_cnt++;
    end
  endtask

  task automatic test_miss();
    lut_a = LUT_T1;
    key_a = 3'd5;
    def_a = 8'h00;
    #1;
    total++;
    if (out_a !== 8'h00 || hit_a !== 1'b0 || multi_a !== 1'b0)
      $display("FAIL miss_zero: got out=%h hit=%b multi=%b expected out=00 hit=0 multi=0",
               out_a, hit_a, multi_a);
    else pass_cnt++;
    def_a = 8'ha5;
    #1;
    total++;
    if (out_a !== 8'ha5 || hit_a !== 1'b0)
      $display("FAIL miss_default: got out=%h hit=%b expected out=a5 hit=0", out_a, hit_a);
    else pass_cnt++;
  endtask

  task automatic test_duplicate();
    lut_a = LUT_T3;
    def_a = 8'h00;
    key_a = 3'd2;
    #1;
    total++;
    if (out_a !== 8'hff || hit_a !== 1'b1 || multi_a !== 1'b1)
      $display("FAIL duplicate: got out=%h hit=%b multi=%b expected out=ff hit=1 multi=1",
               out_a, hit_a, multi_a);
    else pass_cnt++;
    key_a = 3'd1;
    #1;
    total++;
    if (out_a !== 8'h03 || multi_a !== 1'b0)
      $display("FAIL duplicate_single: got out=%h multi=%b expected out=03 multi=0",
               out_a, multi_a);
    else pass_cnt++;
  endtask

  task automatic test_registered();
    @(negedge clk);
    lut_a = LUT_T1;
    def_a = 8'h00;
    key_a = 3'd1;
    en_a  = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (out_q_a !== 8'h03 || hit_q_a !== 1'b1)
      $display("FAIL reg_load: got out_q=%h hit_q=%b expected out_q=03 hit_q=1", out_q_a, hit_q_a);
    else pass_cnt++;
    @(negedge clk);
    en_a  = 1'b0;
    key_a = 3'd3;
    @(posedge clk);
    #1;
    total++;
    if (out_q_a !== 8'h03 || hit_q_a !== 1'b1)
      $display("FAIL reg_hold: got out_q=%h hit_q=%b expected out_q=03 hit_q=1", out_q_a, hit_q_a);
    else pass_cnt++;
    @(negedge clk);
    key_a = 3'd6;
    en_a  = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (out_q_a !== 8'h00 || hit_q_a !== 1'b0)
      $display("FAIL reg_miss: got out_q=%h hit_q=%b expected out_q=00 hit_q=0", out_q_a, hit_q_a);
    else pass_cnt++;
  endtask

  task automatic test_reset_midrun();
    @(negedge clk);
    key_a = 3'd3;
    en_a  = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (out_q_a !== 8'hff) $display("FAIL midrun_preload: got %h expected ff", out_q_a);
    else pass_cnt++;
    #1;
    rst = 1'b1;
    #1;
    total++;
    if (out_q_a !== 8'h00 || hit_q_a !== 1'b0)
      $display("FAIL midrun_async: got out_q=%h hit_q=%b expected out_q=00 hit_q=0",
               out_q_a, hit_q_a);
    else pass_cnt++;
    @(negedge clk);
    rst   = 1'b0;
    en_a  = 1'b1;
    key_a = 3'd2;
    @(posedge clk);
    #1;
    total++;
    if (out_q_a !== 8'h0f || hit_q_a !== 1'b1)
      $display("FAIL midrun_reload: got out_q=%h hit_q=%b expected out_q=0f hit_q=1",
               out_q_a, hit_q_a);
    else pass_cnt++;
  endtask

  task automatic test_lane_select();
    logic [63:0] exp_out;
    logic        exp_hit;
    lut_b = {3'd0, LO32, 3'd4, HI32};
    def_b = 64'h1234_5678_9abc_def0;
    for (int k = 0; k < 8; k++) begin
      key_b = 3'(k);
      exp_hit = (k == 0) || (k == 4);
      exp_out = (k == 0) ? LO32 : (k == 4) ? HI32 : def_b;
      #1;
      total++;
      if (out_b !== exp_out || hit_b !== exp_hit || multi_b !== 1'b0)
        $display("FAIL lane key=%0d: got out=%h hit=%b multi=%b expected out=%h hit=%b multi=0",
                 k, out_b, hit_b, multi_b, exp_out, exp_hit);
      else pass_cnt++;
    end
    @(negedge clk);
    key_b = 3'd4;
    @(posedge clk);
    #1;
    total++;
    if (out_q_b !== HI32 || hit_q_b !== 1'b1)
      $display("FAIL lane_reg: got out_q=%h hit_q=%b expected out_q=%h hit_q=1",
               out_q_b, hit_q_b, HI32);
    else pass_cnt++;
  endtask

  task automatic test_single_entry();
    lut_c = {2'd1, 4'ha};
    def_c = 4'h3;
    key_c = 2'd1;
    #1;
    total++;
    if (out_c !== 4'ha || hit_c !== 1'b1 || multi_c !== 1'b0)
      $display("FAIL single_hit: got out=%h hit=%b multi=%b expected out=a hit=1 multi=0",
               out_c, hit_c, multi_c);
    else pass_cnt++;
    key_c = 2'd2;
    #1;
    total++;
    if (out_c !== 4'h3 || hit_c !== 1'b0 || multi_c !== 1'b0)
      $display("FAIL single_miss: got out=%h hit=%b multi=%b expected out=3 hit=0 multi=0",
               out_c, hit_c, multi_c);
    else pass_cnt++;
  endtask

  initial begin
    key_a = '0; lut_a = '0; def_a = '0; en_a = 1'b0;
    key_b = '0; lut_b = '0; def_b = '0;
    key_c = '0; lut_c = '0; def_c = '0;
    test_reset();
    test_lookup();
    test_miss();
    test_duplicate();
    test_registered();
    test_reset_midrun();
    test_lane_select();
    test_single_entry();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
